// File: rtl/core_types_pkg.sv
// ---------------------------------------------------------------------------
// core_types_pkg
//   Shared core types. Along with the tag, ROB index and checkpoint column
//   types, it provides the physical-register free-list types:
//   FL_DEPTH, free_list_ptr_t (wrap bit + 5-bit index) and prfl_checkpoint_t.
// ---------------------------------------------------------------------------
package core_types_pkg;

   localparam int unsigned NUM_PHYS_REGS      = 64;
   localparam int unsigned NUM_ARCH_REGS      = 32;
   localparam int unsigned CHECKPOINT_COLUMNS = 4;
   localparam int unsigned ROB_ENTRIES        = 64;
   localparam int unsigned FL_DEPTH           = NUM_PHYS_REGS - NUM_ARCH_REGS;

   typedef logic [$clog2(NUM_PHYS_REGS)-1:0]      phys_reg_tag_t;
   typedef logic [$clog2(ROB_ENTRIES)-1:0]        ROB_index_t;
   typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;

   // bit 5 = wrap, bits 4:0 = buffer index
   typedef logic [$clog2(FL_DEPTH):0] free_list_ptr_t;

   typedef struct packed {
      logic           valid;
      ROB_index_t     ROB_index;
      free_list_ptr_t head;
   } prfl_checkpoint_t;

   // Head-side action chosen for the cycle, highest priority first.
   typedef enum logic [2:0] {
      HA_NONE,
      HA_REVERT,
      HA_RESTORE,
      HA_SAVE,
      HA_DEQUEUE
   } head_action_e;

endpackage

// File: rtl/prfl_checkpoint_array.sv
// ---------------------------------------------------------------------------
// prfl_checkpoint_array
//   Per-column snapshots of the free-list head pointer, indexed like the
//   map-table checkpoint columns.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_save_en           write {1, rob, head} into i_save_col (already arbitrated)
//   i_save_col/rob/head save column, ROB tag and head pointer
//   i_restore_valid     restore/invalidate request on i_restore_col
//   i_restore_failed    1 = restore head, 0 = invalidate only
//   i_restore_rob       ROB tag that must match the stored one
//   i_restore_col       column looked up
//   i_restore_en        the restore is taking effect (invalidate other columns)
//   o_success           comb: requested column valid and ROB tag matches
//   o_restore_head      head pointer stored in the requested column
// ---------------------------------------------------------------------------
module prfl_checkpoint_array
   import core_types_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_save_en,
   input  checkpoint_column_t i_save_col,
   input  ROB_index_t         i_save_rob,
   input  free_list_ptr_t     i_save_head,
   input  logic               i_restore_valid,
   input  logic               i_restore_failed,
   input  ROB_index_t         i_restore_rob,
   input  checkpoint_column_t i_restore_col,
   input  logic               i_restore_en,
   output logic               o_success,
   output free_list_ptr_t     o_restore_head
);

   prfl_checkpoint_t   r_ckpt [CHECKPOINT_COLUMNS];
   prfl_checkpoint_t   w_sel;
   checkpoint_column_t w_save_prev_col;
   logic               w_inval_en;

   always_comb begin
      w_sel           = r_ckpt[i_restore_col];
      o_success       = i_restore_valid & w_sel.valid & (w_sel.ROB_index == i_restore_rob);
      o_restore_head  = w_sel.head;
      w_save_prev_col = i_save_col - checkpoint_column_t'(1);
      // A save to the same column overrides the invalidate.
      w_inval_en      = o_success & ~i_restore_failed &
                        ~(i_save_en & (i_save_col == i_restore_col));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < CHECKPOINT_COLUMNS; i++) begin
            r_ckpt[i] <= '0;
         end
         r_ckpt[0].valid <= 1'b1;
      end else begin
         if (i_restore_en) begin
            for (int unsigned i = 0; i < CHECKPOINT_COLUMNS; i++) begin
               if (checkpoint_column_t'(i) != i_restore_col) begin
                  r_ckpt[i].valid <= 1'b0;
               end
            end
         end
         if (w_inval_en) begin
            r_ckpt[i_restore_col].valid <= 1'b0;
         end
         if (i_save_en) begin
            r_ckpt[i_save_col]                <= '{valid: 1'b1, ROB_index: i_save_rob, head: i_save_head};
            r_ckpt[w_save_prev_col].ROB_index <= i_save_rob;
         end
      end
   end

endmodule

// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
//   Circular FIFO of free physical register tags. Dispatch dequeues rename
//   tags, commit enqueues freed tags, revert undoes the youngest dequeue and
//   a failed-speculation restore rewinds head from a checkpoint column.
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   DUT_error                         registered, sticky protocol-error flag
//   dequeue_valid/_phys_reg_tag       head tag available / head tag
//   dequeue_ready                     rename consumes the head tag
//   enqueue_valid/_phys_reg_tag       commit frees a tag
//   revert_valid/_speculated_...      return the tag at head-1
//   save_checkpoint_*                 snapshot head into a column
//   restore_checkpoint_*              restore (failed=1) or invalidate (failed=0)
//   restore_checkpoint_success        comb: column valid and ROB tag match
//   free_count                        tail - head, 0..32
// Configuration:
//   PRFL_DUT_ERROR_EN  defined: protocol checks drive DUT_error and print
//                      a message; undefined: DUT_error tied 0, checks removed.
// ---------------------------------------------------------------------------
module phys_reg_free_list
   import core_types_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   output logic               DUT_error,
   output logic               dequeue_valid,
   output phys_reg_tag_t      dequeue_phys_reg_tag,
   input  logic               dequeue_ready,
   input  logic               enqueue_valid,
   input  phys_reg_tag_t      enqueue_phys_reg_tag,
   input  logic               revert_valid,
   input  phys_reg_tag_t      revert_speculated_dest_phys_reg_tag,
   input  logic               save_checkpoint_valid,
   input  ROB_index_t         save_checkpoint_ROB_index,
   input  checkpoint_column_t save_checkpoint_column,
   input  logic               restore_checkpoint_valid,
   input  logic               restore_checkpoint_speculate_failed,
   input  ROB_index_t         restore_checkpoint_ROB_index,
   input  checkpoint_column_t restore_checkpoint_safe_column,
   output logic               restore_checkpoint_success,
   output logic [5:0]         free_count
);

   localparam free_list_ptr_t FULL_COUNT = free_list_ptr_t'(FL_DEPTH);

   phys_reg_tag_t  r_buf [FL_DEPTH];
   free_list_ptr_t r_head;
   free_list_ptr_t r_tail;

   head_action_e   w_action;
   free_list_ptr_t w_head_dec;
   free_list_ptr_t w_next_head;
   free_list_ptr_t w_next_count;
   free_list_ptr_t w_ckpt_head;
   logic           w_full;
   logic           w_empty;
   logic           w_enq_do;
   logic           w_restore_en;

   prfl_checkpoint_array u_ckpt (
      .i_clk            (CLK),
      .i_rst            (RST),
      .i_save_en        (w_action == HA_SAVE),
      .i_save_col       (save_checkpoint_column),
      .i_save_rob       (save_checkpoint_ROB_index),
      .i_save_head      (r_head),
      .i_restore_valid  (restore_checkpoint_valid),
      .i_restore_failed (restore_checkpoint_speculate_failed),
      .i_restore_rob    (restore_checkpoint_ROB_index),
      .i_restore_col    (restore_checkpoint_safe_column),
      .i_restore_en     (w_restore_en),
      .o_success        (restore_checkpoint_success),
      .o_restore_head   (w_ckpt_head)
   );

   always_comb begin
      w_empty              = (r_head == r_tail);
      w_full               = (r_head[4:0] == r_tail[4:0]) && (r_head[5] != r_tail[5]);
      dequeue_valid        = ~w_empty;
      dequeue_phys_reg_tag = r_buf[r_head[4:0]];
      free_count           = r_tail - r_head;
      w_head_dec           = r_head - free_list_ptr_t'(1);

      w_action = HA_NONE;
      if (revert_valid)                                                             w_action = HA_REVERT;
      else if (restore_checkpoint_valid && restore_checkpoint_speculate_failed)     w_action = HA_RESTORE;
      else if (save_checkpoint_valid)                                               w_action = HA_SAVE;
      else if (dequeue_ready)                                                       w_action = HA_DEQUEUE;

      w_restore_en = (w_action == HA_RESTORE) & restore_checkpoint_success;

      // Illegal revert (full) and dequeue (empty) leave head alone.
      w_next_head = r_head;
      unique case (w_action)
         HA_REVERT:  if (!w_full)       w_next_head = w_head_dec;
         HA_RESTORE: if (w_restore_en)  w_next_head = w_ckpt_head;
         HA_DEQUEUE: if (!w_empty)      w_next_head = r_head + free_list_ptr_t'(1);
         default:    ;
      endcase

      // Fullness judged after the head action; >= also covers an overflowing restore.
      w_next_count = r_tail - w_next_head;
      w_enq_do     = enqueue_valid & (w_next_count < FULL_COUNT);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_head <= '0;
         r_tail <= FULL_COUNT;
         for (int unsigned i = 0; i < FL_DEPTH; i++) begin
            r_buf[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
         end
      end else begin
         r_head <= w_next_head;
         if (w_enq_do) begin
            r_buf[r_tail[4:0]] <= enqueue_phys_reg_tag;
            r_tail             <= r_tail + free_list_ptr_t'(1);
         end
      end
   end

`ifdef PRFL_DUT_ERROR_EN
   logic           r_error;
   logic           w_err;
   free_list_ptr_t w_restore_count;

   always_comb begin
      w_restore_count = r_tail - w_ckpt_head;
      w_err           = 1'b0;
      unique case (w_action)
         HA_REVERT:  w_err = w_full
                           | (r_buf[w_head_dec[4:0]] != revert_speculated_dest_phys_reg_tag)
                           | (restore_checkpoint_valid & restore_checkpoint_speculate_failed)
                           | save_checkpoint_valid | dequeue_ready;
         HA_RESTORE: w_err = (w_restore_en & (w_restore_count > FULL_COUNT))
                           | save_checkpoint_valid | dequeue_ready;
         HA_SAVE:    w_err = dequeue_ready;
         HA_DEQUEUE: w_err = w_empty;
         default:    w_err = 1'b0;
      endcase
      if (enqueue_valid && !w_enq_do) w_err = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_error <= 1'b0;
      end else begin
         r_error <= r_error | w_err;
         if (w_err) $display("[%0t] phys_reg_free_list: protocol error (action %s)", $realtime, w_action.name());
      end
   end

   assign DUT_error = r_error;
`else
   assign DUT_error = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_free_list
//   Reference model: the free list is a queue of tags; dequeued tags are kept
//   on a stack so revert/restore can push them back to the front. A
//   checkpoint remembers how many tags were outstanding when it was saved.
// ---------------------------------------------------------------------------
module tb_phys_reg_free_list;
   import core_types_pkg::*;

`ifdef PRFL_DUT_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic               CLK = 1'b0;
   logic               RST;
   logic               DUT_error;
   logic               dequeue_valid;
   phys_reg_tag_t      dequeue_phys_reg_tag;
   logic               dq_ready;
   logic               enq_v;
   phys_reg_tag_t      enq_tag;
   logic               rev_v;
   phys_reg_tag_t      rev_tag;
   logic               sv_v;
   ROB_index_t         sv_rob;
   checkpoint_column_t sv_col;
   logic               rv_v;
   logic               rv_fail;
   ROB_index_t         rv_rob;
   checkpoint_column_t rv_col;
   logic               restore_checkpoint_success;
   logic [5:0]         free_count;

   phys_reg_free_list dut (
      .CLK                                 (CLK),
      .RST                                 (RST),
      .DUT_error                           (DUT_error),
      .dequeue_valid                       (dequeue_valid),
      .dequeue_phys_reg_tag                (dequeue_phys_reg_tag),
      .dequeue_ready                       (dq_ready),
      .enqueue_valid                       (enq_v),
      .enqueue_phys_reg_tag                (enq_tag),
      .revert_valid                        (rev_v),
      .revert_speculated_dest_phys_reg_tag (rev_tag),
      .save_checkpoint_valid               (sv_v),
      .save_checkpoint_ROB_index           (sv_rob),
      .save_checkpoint_column              (sv_col),
      .restore_checkpoint_valid            (rv_v),
      .restore_checkpoint_speculate_failed (rv_fail),
      .restore_checkpoint_ROB_index        (rv_rob),
      .restore_checkpoint_safe_column      (rv_col),
      .restore_checkpoint_success          (restore_checkpoint_success),
      .free_count                          (free_count)
   );

   always #5 CLK = ~CLK;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // model state
   int          fq[$];
   int          popped[$];
   bit          ck_valid [4];
   int          ck_rob   [4];
   int          ck_pos   [4];
   bit          exp_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      dq_ready = 0; enq_v = 0; enq_tag = '0; rev_v = 0; rev_tag = '0;
      sv_v = 0; sv_rob = '0; sv_col = '0; rv_v = 0; rv_fail = 0; rv_rob = '0; rv_col = '0;
   endtask

   task automatic model_reset();
      fq.delete();
      popped.delete();
      for (int i = 0; i < 32; i++) fq.push_back(32 + i);
      for (int c = 0; c < 4; c++) begin
         ck_valid[c] = (c == 0);
         ck_rob[c]   = 0;
         ck_pos[c]   = 0;
      end
      exp_err = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1;
      @(posedge CLK);
      #1;
      RST = 0;
      model_reset();
   endtask

   task automatic model_step(input bit succ);
      bit err   = 0;
      bit saved = 0;
      if (rev_v) begin
         if (fq.size() >= 32 || popped.size() == 0) err = 1;
         else begin
            if (popped[$] != int'(rev_tag)) err = 1;
            fq.push_front(popped.pop_back());
         end
         if ((rv_v && rv_fail) || sv_v || dq_ready) err = 1;
      end else if (rv_v && rv_fail) begin
         if (succ) begin
            while (popped.size() > ck_pos[rv_col]) fq.push_front(popped.pop_back());
            for (int c = 0; c < 4; c++) if (c != int'(rv_col)) ck_valid[c] = 0;
         end
         if (sv_v || dq_ready) err = 1;
      end else if (sv_v) begin
         saved = 1;
         if (dq_ready) err = 1;
      end else if (dq_ready) begin
         if (fq.size() == 0) err = 1;
         else popped.push_back(fq.pop_front());
      end
      if (rv_v && !rv_fail && succ && !(saved && sv_col == rv_col)) ck_valid[rv_col] = 0;
      if (saved) begin
         ck_valid[sv_col] = 1;
         ck_rob[sv_col]   = int'(sv_rob);
         ck_pos[sv_col]   = popped.size();
         ck_rob[2'(sv_col - 2'd1)] = int'(sv_rob);
      end
      if (enq_v) begin
         if (fq.size() >= 32) err = 1;
         else fq.push_back(int'(enq_tag));
      end
      if (ERR_EN && err) exp_err = 1;
   endtask

   // Inputs are already driven; compare outputs, clock once, advance model.
   task automatic tick();
      bit succ;
      #1;
      succ = rv_v && ck_valid[rv_col] && (ck_rob[rv_col] == int'(rv_rob));
      chk("dq_valid", dequeue_valid, fq.size() != 0);
      if (fq.size() != 0) chk("dq_tag", dequeue_phys_reg_tag, fq[0]);
      chk("free_count", free_count, fq.size());
      chk("success", restore_checkpoint_success, succ);
      chk("dut_error", DUT_error, exp_err);
      @(posedge CLK);
      model_step(succ);
      #1;
      clear_inputs();
   endtask

   task automatic deq_n(input int n);
      for (int i = 0; i < n; i++) begin
         dq_ready = 1;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      RST = 1;
      repeat (2) @(posedge CLK);
      do_reset();

      // 1: reset state, drain, dequeue while empty
      chk("rst_valid", dequeue_valid, 1);
      chk("rst_tag", dequeue_phys_reg_tag, 32);
      chk("rst_count", free_count, 32);
      chk("rst_success", restore_checkpoint_success, 0);
      chk("rst_error", DUT_error, 0);
      for (int i = 0; i < 32; i++) begin
         #1;
         chk("t1_tag", dequeue_phys_reg_tag, 32 + i);
         dq_ready = 1;
         tick();
      end
      chk("t1_valid", dequeue_valid, 0);
      chk("t1_count", free_count, 0);
      dq_ready = 1;
      tick();
      chk("t1_err", DUT_error, ERR_EN);

      // 2: enqueue into empty list, same-cycle dequeue+enqueue
      enq_v = 1; enq_tag = 5;
      #1;
      chk("t2_valid_same", dequeue_valid, 0);
      tick();
      chk("t2_valid_next", dequeue_valid, 1);
      chk("t2_tag", dequeue_phys_reg_tag, 5);
      enq_v = 1; enq_tag = 6; tick();
      enq_v = 1; enq_tag = 7; tick();
      dq_ready = 1; enq_v = 1; enq_tag = 8; tick();
      chk("t2_count", free_count, 3);
      chk("t2_tag2", dequeue_phys_reg_tag, 6);

      // 3: revert
      do_reset();
      deq_n(9);
      rev_v = 1; rev_tag = 40; tick();
      chk("t3_tag", dequeue_phys_reg_tag, 40);
      rev_v = 1; rev_tag = 41; tick();
      chk("t3_err", DUT_error, ERR_EN);

      // 4: save, dequeue, restore
      do_reset();
      deq_n(2);
      sv_v = 1; sv_col = 1; sv_rob = 7; tick();
      deq_n(3);
      rv_v = 1; rv_fail = 1; rv_col = 1; rv_rob = 7;
      #1;
      chk("t4_success", restore_checkpoint_success, 1);
      tick();
      chk("t4_tag", dequeue_phys_reg_tag, 34);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) continue;
         rv_v = 1; rv_fail = 1; rv_col = 2'(c); rv_rob = (c == 0) ? 6'd7 : 6'd0;
         #1;
         chk("t4_other_inval", restore_checkpoint_success, 0);
         tick();
      end
      rv_v = 1; rv_fail = 1; rv_col = 1; rv_rob = 8;
      #1;
      chk("t4_rob_mismatch", restore_checkpoint_success, 0);
      tick();
      chk("t4_tag_kept", dequeue_phys_reg_tag, 34);

      // 5: invalidate concurrent with dequeue
      do_reset();
      sv_v = 1; sv_col = 1; sv_rob = 7; tick();
      rv_v = 1; rv_fail = 0; rv_col = 1; rv_rob = 7; dq_ready = 1;
      #1;
      chk("t5_inval_success", restore_checkpoint_success, 1);
      tick();
      chk("t5_deq_tag", dequeue_phys_reg_tag, 33);
      rv_v = 1; rv_fail = 1; rv_col = 1; rv_rob = 7;
      #1;
      chk("t5_restore_after_inval", restore_checkpoint_success, 0);
      tick();

      // 6: random dequeue/enqueue across pointer wrap
      do_reset();
      for (int i = 0; i < 100; i++) begin
         dq_ready = ($urandom_range(9) < 6);
         enq_v    = $urandom_range(1);
         enq_tag  = phys_reg_tag_t'($urandom);
         tick();
      end
      #1;
      chk("t6_count", free_count, fq.size());
      chk("t6_err", DUT_error, exp_err);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
